// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, issues reads to a 1-cycle instruction memory and
// buffers returned instructions for decode. Optional HALT_EN macro adds halt-on-opcode-111.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       INSTR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               jmp_valid,
  input  logic [ADDR_W-1:0]  jmp_target,
  output logic               halted
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

`ifdef HALT_EN
  typedef enum logic [1:0] {ST_RESET = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_RESET = 2'd0, ST_RUN = 2'd1} state_t;
`endif

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;
  logic [CNT_W-1:0]   count;

  // Shift-style buffer: entry 0 is always the head, so head outputs come straight from flops.
  logic [INSTR_W-1:0] buf_instr [BUF_DEPTH];
  logic [ADDR_W-1:0]  buf_pc    [BUF_DEPTH];

  logic               pop_c;
  logic               halt_pop_c;
  logic               flush_c;
  logic               run_c;
  logic               issue_c;
  logic               push_c;
  logic [CNT_W:0]     occ_c;
  logic [CNT_W-1:0]   wr_idx_c;
  logic [CNT_W-1:0]   count_next_c;

  assign pop_c = if_valid & id_ready;

`ifdef HALT_EN
  logic buf_mark [BUF_DEPTH];
  assign halt_pop_c = pop_c & buf_mark[0] & ~jmp_valid;
  assign run_c      = (state != ST_HALT);
`else
  assign halt_pop_c = 1'b0;
  assign run_c      = 1'b1;
`endif

  // Redirect or halt discards everything left in the buffer and the outstanding read.
  assign flush_c      = jmp_valid | halt_pop_c;
  assign occ_c        = (CNT_W+1)'(count) - (CNT_W+1)'(pop_c) + (CNT_W+1)'(inflight);
  assign issue_c      = ~flush_c & run_c &
                        ((state == ST_RESET) || (occ_c < (CNT_W+1)'(BUF_DEPTH)));
  assign push_c       = inflight & ~flush_c;
  assign wr_idx_c     = count - CNT_W'(pop_c);
  assign count_next_c = flush_c ? '0 : (wr_idx_c + CNT_W'(push_c));

  assign if_instr = buf_instr[0];
  assign if_pc    = buf_pc[0];

  // Control FSM, PC, fetch address and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RESET;
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      if_valid    <= 1'b0;
    end else begin
      inflight <= issue_c;
      if (issue_c) inflight_pc <= pc;
      count    <= count_next_c;
      if_valid <= (count_next_c != '0);

      if (jmp_valid) begin
        pc        <= jmp_target;
        imem_addr <= jmp_target;
      end else if (issue_c) begin
        pc        <= pc + ADDR_W'(1);
        imem_addr <= pc + ADDR_W'(1);
      end

      case (state)
        ST_RESET: state <= ST_RUN;
`ifdef HALT_EN
        ST_RUN:   if (halt_pop_c) state <= ST_HALT;
        ST_HALT:  if (jmp_valid) state <= ST_RUN;
`else
        ST_RUN:   state <= ST_RUN;
`endif
        default:  state <= ST_RUN;
      endcase
    end
  end

`ifdef HALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted <= 1'b0;
    else        halted <= halt_pop_c | (halted & ~jmp_valid);
  end
`else
  assign halted = 1'b0;
`endif

  // Buffer storage: shift on pop, then write the captured read at the post-pop tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_instr[IDX_W'(i)] <= '0;
        buf_pc[IDX_W'(i)]    <= '0;
`ifdef HALT_EN
        buf_mark[IDX_W'(i)]  <= 1'b0;
`endif
      end
    end else begin
      if (pop_c) begin
        for (int unsigned i = 0; i + 1 < BUF_DEPTH; i++) begin
          buf_instr[IDX_W'(i)] <= buf_instr[IDX_W'(i + 1)];
          buf_pc[IDX_W'(i)]    <= buf_pc[IDX_W'(i + 1)];
`ifdef HALT_EN
          buf_mark[IDX_W'(i)]  <= buf_mark[IDX_W'(i + 1)];
`endif
        end
      end
      if (push_c) begin
        buf_instr[IDX_W'(wr_idx_c)] <= imem_instr;
        buf_pc[IDX_W'(wr_idx_c)]    <= inflight_pc;
`ifdef HALT_EN
        buf_mark[IDX_W'(wr_idx_c)]  <= (imem_instr[7:5] == 3'b111);
`endif
      end
    end
  end

  // The issue rule reserves a slot for every outstanding read.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_c && (wr_idx_c >= CNT_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// run checked against a program-order stream model.
module tb_instr_fetch_unit;

  localparam int unsigned BUF_DEPTH = 2;
  localparam logic [7:0]  RESET_PC  = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic [7:0] imem_instr;
  logic       if_valid;
  logic [7:0] if_instr;
  logic [7:0] if_pc;
  logic       id_ready;
  logic       jmp_valid;
  logic [7:0] jmp_target;
  logic       halted;

  logic [7:0] mem  [256];
  logic [7:0] prog [5];
  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit #(
    .ADDR_W(8), .INSTR_W(8), .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .halted(halted)
  );

  always #5 clk = ~clk;

  // Registered-read memory: data reflects the address sampled at the previous edge.
  always @(posedge clk) imem_instr <= mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    prog[0] = 8'h88; prog[1] = 8'h48; prog[2] = 8'h6C; prog[3] = 8'h08; prog[4] = 8'h29;
    for (int i = 0; i < 5; i++) mem[i] = prog[i];
    mem[255] = 8'hA0;
  endtask

  // Hold reset for two edges, release just after an edge.
  task automatic do_reset();
    rst_n = 1'b0; id_ready = 1'b0; jmp_valid = 1'b0; jmp_target = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_ready = 1'b0; jmp_valid = 1'b0; jmp_target = 8'h00;
    tick();
    tick();
    n_cmp++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_instr !== 8'h00) begin n_bad++; $display("FAIL reset_instr: got %h want 00", if_instr); end
    n_cmp++; if (if_pc !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %h want 00", if_pc); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    rst_n = 1'b1;
    id_ready = 1'b1;
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL latency_edge1: valid got %b want 0", if_valid); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 8'(k) || if_instr !== prog[k]) begin
        n_bad++;
        $display("FAIL stream[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, if_valid, if_pc, if_instr, 8'(k), prog[k]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    id_ready = 1'b1;
    tick();
    tick();
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_instr !== 8'h88 || if_pc !== 8'h00) begin
        n_bad++;
        $display("FAIL stall_head[%0d]: got v=%b pc=%h i=%h want v=1 pc=00 i=88", k, if_valid, if_pc, if_instr);
      end
      n_cmp++;
      if (imem_addr !== RESET_PC + 8'(BUF_DEPTH)) begin
        n_bad++;
        $display("FAIL stall_addr[%0d]: got %h want %h", k, imem_addr, RESET_PC + 8'(BUF_DEPTH));
      end
    end
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 8'(k) || if_instr !== prog[k]) begin
        n_bad++;
        $display("FAIL stall_release[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, if_valid, if_pc, if_instr, 8'(k), prog[k]);
      end
      tick();
    end
  endtask

  task automatic test_jump();
    do_reset();
    id_ready = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++; if (if_pc !== 8'h01 || if_instr !== 8'h48) begin n_bad++; $display("FAIL jump_pre: got pc=%h i=%h want pc=01 i=48", if_pc, if_instr); end
    jmp_valid = 1'b1; jmp_target = 8'h03;
    tick();
    jmp_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL jump_squash1: valid got %b want 0", if_valid); end
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL jump_squash2: valid got %b want 0", if_valid); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 8'h03 || if_instr !== 8'h08) begin n_bad++; $display("FAIL jump_first: got v=%b pc=%h i=%h want v=1 pc=03 i=08", if_valid, if_pc, if_instr); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 8'h04 || if_instr !== 8'h29) begin n_bad++; $display("FAIL jump_second: got v=%b pc=%h i=%h want v=1 pc=04 i=29", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_wrap();
    do_reset();
    id_ready = 1'b1;
    tick();
    tick();
    tick();
    jmp_valid = 1'b1; jmp_target = 8'hFF;
    tick();
    jmp_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 8'hFF || if_instr !== 8'hA0) begin n_bad++; $display("FAIL wrap_ff: got v=%b pc=%h i=%h want v=1 pc=ff i=a0", if_valid, if_pc, if_instr); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 8'h88) begin n_bad++; $display("FAIL wrap_00: got v=%b pc=%h i=%h want v=1 pc=00 i=88", if_valid, if_pc, if_instr); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 8'h01 || if_instr !== 8'h48) begin n_bad++; $display("FAIL wrap_01: got v=%b pc=%h i=%h want v=1 pc=01 i=48", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    id_ready = 1'b1;
    tick();
    tick();
    tick();
    id_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: valid got %b want 1", if_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== RESET_PC) begin n_bad++; $display("FAIL midrst_async: got v=%b addr=%h want v=0 addr=%h", if_valid, imem_addr, RESET_PC); end
    tick();
    rst_n = 1'b1;
    id_ready = 1'b1;
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_edge1: valid got %b want 0", if_valid); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 8'h88) begin n_bad++; $display("FAIL midrst_restart: got v=%b pc=%h i=%h want v=1 pc=00 i=88", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_opcode111();
    mem[2] = 8'hE0;
    do_reset();
    id_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 8'h02 || if_instr !== 8'hE0) begin n_bad++; $display("FAIL op111_head: got v=%b pc=%h i=%h want v=1 pc=02 i=e0", if_valid, if_pc, if_instr); end
    tick();
`ifdef HALT_EN
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (halted !== 1'b1 || if_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL halt_hold[%0d]: got h=%b v=%b want h=1 v=0", k, halted, if_valid);
      end
      tick();
    end
    jmp_valid = 1'b1; jmp_target = 8'h00;
    tick();
    jmp_valid = 1'b0;
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_exit: halted got %b want 0", halted); end
    tick();
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 8'h88) begin n_bad++; $display("FAIL halt_resume: got v=%b pc=%h i=%h want v=1 pc=00 i=88", if_valid, if_pc, if_instr); end
`else
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 8'h03 || if_instr !== 8'h08 || halted !== 1'b0) begin n_bad++; $display("FAIL op111_pass: got v=%b pc=%h i=%h h=%b want v=1 pc=03 i=08 h=0", if_valid, if_pc, if_instr, halted); end
`endif
    mem[2] = 8'h6C;
  endtask

  // Random ready/redirect traffic against a program-order model of the delivered stream.
  task automatic test_random();
    logic [7:0] exp_pc;
    logic       halted_m;
    logic       stable_chk;
    logic [7:0] prev_instr;
    logic [7:0] prev_pc;
    logic       hs;
    int         idle;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    do_reset();
    exp_pc = RESET_PC; halted_m = 1'b0; stable_chk = 1'b0; idle = 0;
    prev_instr = 8'h00; prev_pc = 8'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (stable_chk) begin
        n_cmp++;
        if (if_valid !== 1'b1 || if_instr !== prev_instr || if_pc !== prev_pc) begin
          n_bad++;
          $display("FAIL rnd_hold@%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", cyc, if_valid, if_pc, if_instr, prev_pc, prev_instr);
        end
      end
      n_cmp++;
      if (halted !== halted_m) begin n_bad++; $display("FAIL rnd_halted@%0d: got %b want %b", cyc, halted, halted_m); end
      if (halted_m) begin
        n_cmp++;
        if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_halt_valid@%0d: got %b want 0", cyc, if_valid); end
      end
      if (!if_valid && !halted_m) idle++;
      else idle = 0;
      if (idle > 2) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_gap@%0d: invalid for %0d cycles want at most 2", cyc, idle);
        idle = 0;
      end

      id_ready   = ($urandom_range(0, 9) < 7);
      jmp_valid  = ($urandom_range(0, 19) == 0);
      jmp_target = 8'($urandom_range(0, 255));
      hs = if_valid & id_ready;
      if (hs) begin
        n_cmp++;
        if (if_pc !== exp_pc || if_instr !== mem[exp_pc]) begin
          n_bad++;
          $display("FAIL rnd_pop@%0d: got pc=%h i=%h want pc=%h i=%h", cyc, if_pc, if_instr, exp_pc, mem[exp_pc]);
        end
`ifdef HALT_EN
        if (mem[exp_pc][7:5] == 3'b111 && !jmp_valid) halted_m = 1'b1;
`endif
        exp_pc = exp_pc + 8'd1;
      end
      if (jmp_valid) begin
        exp_pc = jmp_target; halted_m = 1'b0; idle = 0;
      end
      stable_chk = if_valid & ~id_ready & ~jmp_valid;
      prev_instr = if_instr;
      prev_pc    = if_pc;
      tick();
    end
    jmp_valid = 1'b0;
    id_ready  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; id_ready = 1'b0; jmp_valid = 1'b0; jmp_target = 8'h00;
    load_program();
    test_reset();
    test_stall();
    test_jump();
    test_wrap();
    test_reset_mid();
    test_opcode111();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
